div_radix_param: RTL and testbench
==================================

# div_radix_param

Parametrised iterative integer divider for the execute stage's HI/LO path; the next generation of the fixed 32-cycle divider. Takes dividend/divisor under a start/ready handshake, computes signed or unsigned quotient and remainder over WIDTH/RADIX_BITS cycles, and returns {remainder, quotient} for HI/LO write-back. It supports flush (annul), divide-by-zero flagging, and an optional early-termination path.

## Interface
- WIDTH, 32: operand width; must be a multiple of RADIX_BITS.
- RADIX_BITS, 1: quotient bits retired per cycle; legal values 1 or 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- signed_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- annul_i  in  1  flush; aborts any operation in flight.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- result_o  out  2*WIDTH  {remainder, quotient}, in HI/LO order.
- ready_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- busy_o  out  1  high in BUSY and DONE.
- div_zero_o  out  1  divisor was zero; valid while ready_o is high.

## Operation
- States:
  - IDLE: waits for start_i.
  - BUSY: iterates.
  - DONE: asserts ready_o.
- IDLE, start_i=1, annul_i=0:
  - Latch the operand magnitudes (two's-complement absolute value when signed_i=1), the sign of the quotient (dividend sign XOR divisor sign), the sign of the remainder (dividend sign), and the operation mode.
  - Clear the iteration counter.
  - Go to BUSY.
- BUSY: each cycle performs RADIX_BITS restoring steps on the {partial remainder, dividend} shift register. Remainder width is WIDTH+1 so the compare never overflows. The counter increments; after N = WIDTH/RADIX_BITS cycles, go to DONE.
- DONE:
  - Apply sign fix-ups: negate the quotient if its latched sign is negative; negate the remainder if the dividend sign is negative.
  - Register result_o and pulse ready_o.
  - Return to IDLE.
- Divide by zero: go IDLE → DONE directly. Quotient = all ones, remainder = raw dividend, div_zero_o=1.
- Most-negative ÷ −1, signed: quotient = most-negative value (wraps), remainder = 0, no flag.
- annul_i in any state: next state is IDLE, no ready_o pulse, result_o unchanged. In IDLE, annul_i has priority over a simultaneous start_i.
- start_i in BUSY or DONE is ignored; the requester must hold the pipeline until ready_o.
- result_o holds its last value until the next DONE.
- Reset: state IDLE; result_o=0, ready_o=0, busy_o=0, div_zero_o=0, counter=0. Reset mid-operation discards the operation.

## Timing
- Start accepted in cycle 0. BUSY occupies cycles 1..N. ready_o is high in cycle N+1.
- Latency:
  - WIDTH=32, RADIX_BITS=1: 33 cycles.
  - WIDTH=32, RADIX_BITS=2: 17 cycles.
  - Divide by zero or early termination: 1 cycle.
- Back-to-back: a new start_i is accepted in the cycle after ready_o (IDLE). Throughput is N+2 cycles per operation.
- ready_o, busy_o, div_zero_o and result_o are all registered; there are no combinational input-to-output paths.

## Configuration
- DIV_EARLY_TERM_EN defined: in IDLE, if the dividend magnitude < divisor magnitude (divisor ≠ 0), go straight to DONE with quotient=0 and remainder=dividend (sign preserved). Latency is 1 cycle.
- Undefined: such operands take the full N-cycle path. Results are identical in both builds; only latency differs.

## Structure
- Package div_pkg:
  - div_state_t enum {IDLE, BUSY, DONE}.
  - localparam helpers for the counter width, $clog2(WIDTH/RADIX_BITS)+1.
- Sub-module div_step: one combinational restoring step (shift, trial subtract, quotient bit). Instantiated RADIX_BITS times in a chain within the BUSY datapath.
- Sign handling and the FSM live in the top module.

## Test plan
- Unsigned, WIDTH=32, R=1: 100 ÷ 7 → ready_o exactly 33 cycles after start; result_o = {0x2, 0xE}.
- Signed: −7 ÷ 2 → {0xFFFFFFFF, 0xFFFFFFFD}. Also 0x80000000 ÷ 0xFFFFFFFF → {0x0, 0x80000000}, div_zero_o=0.
- Divisor 0, dividend 0x1234 → ready_o in cycle 1, div_zero_o=1, result_o = {0x1234, 0xFFFFFFFF}.
- annul_i in cycle 10 of a BUSY operation → busy_o low in cycle 11, no ready_o, prior result_o retained. A new start in cycle 11 completes normally.
- R=2 build, 0xFFFFFFFF ÷ 0x10 unsigned → ready_o at cycle 17, result_o = {0xF, 0x0FFFFFFF}. A start_i pulsed during BUSY is ignored.
- With DIV_EARLY_TERM_EN: 3 ÷ 5 → ready_o at cycle 1, {0x3, 0x0}. Without the macro, the same result arrives at cycle 33.

Source files
------------

// File: rtl/div_radix_param_pkg.sv
// rtl/div_radix_param_pkg.sv - shared types and sizing helpers for the iterative divider
// Contents:
//   div_state_t            : IDLE / BUSY / DONE controller states
//   DIV_WIDTH_DEFAULT      : default operand width
//   DIV_RADIX_DEFAULT      : default quotient bits retired per cycle
//   cnt_width(w, r)        : iteration counter width, $clog2(w/r)+1
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_RADIX_DEFAULT = 1;

    function automatic int cnt_width(input int width, input int radix);
        return $clog2(width / radix) + 1;
    endfunction

endpackage

// File: rtl/div_radix_param_if.sv
// rtl/div_radix_param_if.sv - request/response bundle between execute stage and divider
// Signals:
//   start_i, signed_i, annul_i, opdata1_i, opdata2_i : requester -> divider
//   result_o {rem, quo}, ready_o, busy_o, div_zero_o  : divider -> requester
// Modports: master (requester side), slave (divider side)
interface div_radix_param_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               signed_i;
    logic               annul_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               div_zero_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/div_radix_param_step.sv
// rtl/div_radix_param_step.sv - one combinational restoring division step
// Ports:
//   i_rem [W:0]   partial remainder in
//   i_dvd [W-1:0] dividend/quotient shift register in (dividend bits leave at MSB)
//   i_dsr [W-1:0] divisor magnitude
//   o_rem [W:0]   partial remainder out
//   o_dvd [W-1:0] shift register out, new quotient bit inserted at LSB
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_dvd,
    input  logic [W-1:0] i_dsr,
    output logic [W:0]   o_rem,
    output logic [W-1:0] o_dvd
);
    logic [W+1:0] w_shift;
    logic [W+1:0] w_diff;
    logic         w_qbit;

    // One extra guard bit so the trial subtract exposes its borrow at the MSB.
    assign w_shift = {i_rem, i_dvd[W-1]};
    assign w_diff  = w_shift - {2'b00, i_dsr};
    assign w_qbit  = ~w_diff[W+1];
    assign o_rem   = w_qbit ? w_diff[W:0] : w_shift[W:0];
    assign o_dvd   = {i_dvd[W-2:0], w_qbit};
endmodule

// File: rtl/div_radix_param.sv
// rtl/div_radix_param.sv - parametrised signed/unsigned iterative divider (HI/LO)
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_radix_param_if.slave (start/signed/annul/operands in; result/ready/busy/div_zero out)
// Parameters: WIDTH (multiple of RADIX_BITS), RADIX_BITS (1 or 2)
// Build option: DIV_EARLY_TERM_EN - finish in one cycle when |dividend| < |divisor|.
module div_radix_param
    import div_pkg::*;
#(
    parameter int WIDTH      = DIV_WIDTH_DEFAULT,
    parameter int RADIX_BITS = DIV_RADIX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    div_radix_param_if.slave  bus
);
    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = cnt_width(WIDTH, RADIX_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    div_state_t          r_state;
    div_state_t          w_next;
    logic [WIDTH:0]      r_rem;
    logic [WIDTH-1:0]    r_dvd;
    logic [WIDTH-1:0]    r_dsr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_q_neg;
    logic                r_r_neg;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_ready;
    logic                r_busy;
    logic                r_div_zero;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic                w_div_zero;
    logic                w_early;
    logic                w_accept;
    logic                w_last_busy;
    logic [WIDTH-1:0]    w_q_fix;
    logic [WIDTH-1:0]    w_r_fix;

    logic [WIDTH:0]      w_rem [0:RADIX_BITS];
    logic [WIDTH-1:0]    w_dvd [0:RADIX_BITS];

    assign w_a_neg    = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign w_b_neg    = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_b_mag    = w_b_neg ? -bus.opdata2_i : bus.opdata2_i;
    assign w_div_zero = (bus.opdata2_i == '0);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = !w_div_zero && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // annul wins over a simultaneous start.
    assign w_accept    = (r_state == IDLE) && bus.start_i && !bus.annul_i;
    assign w_last_busy = (r_state == BUSY) && (r_cnt == LAST_CNT);

    // RADIX_BITS restoring steps chained combinationally per BUSY cycle.
    assign w_rem[0] = r_rem;
    assign w_dvd[0] = r_dvd;
    for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_step
        div_step #(.W(WIDTH)) u_step (
            .i_rem (w_rem[gi]),
            .i_dvd (w_dvd[gi]),
            .i_dsr (r_dsr),
            .o_rem (w_rem[gi+1]),
            .o_dvd (w_dvd[gi+1])
        );
    end

    // Sign fix-ups applied to the last step's outputs so the result is
    // registered on the same edge that enters DONE.
    assign w_q_fix = r_q_neg ? -w_dvd[RADIX_BITS] : w_dvd[RADIX_BITS];
    assign w_r_fix = r_r_neg ? -w_rem[RADIX_BITS][WIDTH-1:0] : w_rem[RADIX_BITS][WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        if (bus.annul_i) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start_i) w_next = (w_div_zero || w_early) ? DONE : BUSY;
                BUSY:    if (r_cnt == LAST_CNT) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_accept) begin
            r_rem   <= '0;
            r_dvd   <= w_a_mag;
            r_dsr   <= w_b_mag;
            r_cnt   <= '0;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
        end else if (r_state == BUSY) begin
            r_rem <= w_rem[RADIX_BITS];
            r_dvd <= w_dvd[RADIX_BITS];
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_busy  <= (w_next != IDLE);
            if (w_accept && (w_div_zero || w_early)) begin
                // Divide-by-zero returns the raw dividend as remainder; the
                // early path has |a| < |b| so the raw dividend is the remainder.
                r_result   <= {bus.opdata1_i, w_div_zero ? {WIDTH{1'b1}} : {WIDTH{1'b0}}};
                r_div_zero <= w_div_zero;
                r_ready    <= 1'b1;
            end else if (w_last_busy && !bus.annul_i) begin
                r_result   <= {w_r_fix, w_q_fix};
                r_div_zero <= 1'b0;
                r_ready    <= 1'b1;
            end
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.busy_o     = r_busy;
    assign bus.div_zero_o = r_div_zero;
endmodule

// File: tb/tb_div_radix_param.sv
// tb/tb_div_radix_param.sv - directed scoreboard bench for div_radix_param (radix 1 and radix 2)
module tb_div_radix_param;

`ifdef DIV_EARLY_TERM_EN
    localparam int ET_LAT = 1;
`else
    localparam int ET_LAT = 33;
`endif

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_radix_param_if #(.WIDTH(32)) b1 ();
    div_radix_param_if #(.WIDTH(32)) b2 ();

    div_radix_param #(.WIDTH(32), .RADIX_BITS(1)) u_r1 (.clk(clk), .rst(rst), .bus(b1));
    div_radix_param #(.WIDTH(32), .RADIX_BITS(2)) u_r2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit st, input bit sg, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            b2.start_i = st; b2.signed_i = sg; b2.opdata1_i = a; b2.opdata2_i = b;
        end else begin
            b1.start_i = st; b1.signed_i = sg; b1.opdata1_i = a; b1.opdata2_i = b;
        end
    endtask

    function automatic logic rd_ready(input bit sel);
        return sel ? b2.ready_o : b1.ready_o;
    endfunction

    function automatic logic rd_busy(input bit sel);
        return sel ? b2.busy_o : b1.busy_o;
    endfunction

    function automatic logic [63:0] rd_result(input bit sel);
        return sel ? b2.result_o : b1.result_o;
    endfunction

    function automatic logic rd_dz(input bit sel);
        return sel ? b2.div_zero_o : b1.div_zero_o;
    endfunction

    // Called at #1 after a rising edge with the selected divider idle; the
    // start is therefore sampled on the next edge (cycle 0).
    task automatic run_op(input bit sel, input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e_res, input bit e_dz, input int e_lat,
                          input int pulse_at, input string tag);
        exp_t e;
        int   lat;
        bit   got;
        e.res = e_res; e.dz = e_dz; e.lat = e_lat;
        sb.push_back(e);
        drive(sel, 1'b1, sg, a, b);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                drive(sel, 1'b0, sg, a, b);
                check({tag, "_busy_c1"}, 64'(rd_busy(sel)), 64'd1);
            end
            if (pulse_at > 0 && c == pulse_at)     drive(sel, 1'b1, ~sg, 32'h5, 32'h3);
            if (pulse_at > 0 && c == pulse_at + 1) drive(sel, 1'b0, sg, a, b);
            if (rd_ready(sel)) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        check({tag, "_ready_seen"}, 64'(got), 64'd1);
        e = sb.pop_front();
        if (got) begin
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
            check({tag, "_result"}, rd_result(sel), e.res);
            check({tag, "_div_zero"}, 64'(rd_dz(sel)), 64'(e.dz));
            @(posedge clk); #1;
            check({tag, "_ready_pulse"}, 64'(rd_ready(sel)), 64'd0);
            check({tag, "_busy_idle"}, 64'(rd_busy(sel)), 64'd0);
            check({tag, "_result_hold"}, rd_result(sel), e.res);
        end
    endtask

    initial begin
        int nrdy;
        rst = 1'b1;
        b1.annul_i = 1'b0;
        b2.annul_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_r1_result", b1.result_o, 64'h0);
        check("rst_r1_flags", {61'h0, b1.ready_o, b1.busy_o, b1.div_zero_o}, 64'h0);
        check("rst_r2_result", b2.result_o, 64'h0);
        check("rst_r2_flags", {61'h0, b2.ready_o, b2.busy_o, b2.div_zero_o}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b0, 33, 0, "u_100_7");
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33, 0, "s_m7_2");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 33, 0, "s_minneg");
        run_op(1'b0, 1'b0, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 1'b1, 1, 0, "u_dz");
        run_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'h0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, 1, 0, "s_dz");
        run_op(1'b0, 1'b0, 32'd3, 32'd5, {32'h3, 32'h0}, 1'b0, ET_LAT, 0, "u_3_5");
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFD, 32'h0}, 1'b0, ET_LAT, 0, "s_m3_5");

        // Flush in cycle 10 of a BUSY operation.
        drive(1'b0, 1'b1, 1'b0, 32'd999, 32'd4);
        nrdy = 0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(1'b0, 1'b0, 1'b0, 32'd999, 32'd4);
            if (b1.ready_o) nrdy++;
            if (c == 10) b1.annul_i = 1'b1;
        end
        b1.annul_i = 1'b0;
        check("annul_busy_c11", 64'(b1.busy_o), 64'd0);
        check("annul_no_ready", 64'(nrdy), 64'd0);
        check("annul_result_kept", b1.result_o, {32'hFFFF_FFFD, 32'h0});
        run_op(1'b0, 1'b0, 32'd1000, 32'd3, {32'h1, 32'h14D}, 1'b0, 33, 0, "after_annul");

        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 1'b0, 17, 5, "r2_ffff_10");
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, 17, 0, "r2_m100_7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
